// File: rtl/pc_redirect_ctrl.sv
// rtl/pc_redirect_ctrl.sv - fetch PC register with prioritized, stall-buffered redirect control
module pc_redirect_ctrl #(
   parameter logic [31:0] RESET_VECTOR = 32'h0000_0000,
   parameter int          CNT_W        = 16
) (
   input  logic             Clk,
   input  logic             Rst_n,
   input  logic             Stall,
   input  logic             JRReq,
   input  logic             JReq,
   input  logic             BranchReq,
   input  logic             BranchTaken,
   input  logic [31:0]      JRAddress,
   input  logic [31:0]      JumpAddress,
   input  logic [31:0]      BranchAddress,
   output logic [31:0]      PC,
   output logic [1:0]       SelCode,
   output logic [31:0]      NextAddress,
   output logic             IF_Flush,
   output logic             AddrErr,
   output logic [CNT_W-1:0] RedirectCount
);

   localparam logic [1:0] SEL_JR  = 2'b00;
   localparam logic [1:0] SEL_J   = 2'b01;
   localparam logic [1:0] SEL_BR  = 2'b10;
   localparam logic [1:0] SEL_SEQ = 2'b11;

   typedef enum logic {RUN, PEND} state_t;

   state_t      state, state_nxt;
   logic [1:0]  pend_code;
   logic [31:0] pend_target;
   logic        req_valid;
   logic [1:0]  win_code;
   logic [31:0] win_target;
   logic [31:0] raw_target;
   logic        apply;
   logic        latch;

   always_comb begin
      req_valid  = 1'b1;
      win_code   = SEL_JR;
      win_target = JRAddress;
      if (JRReq) begin
         win_code   = SEL_JR;
         win_target = JRAddress;
      end else if (JReq) begin
         win_code   = SEL_J;
         win_target = JumpAddress;
      end else if (BranchReq && BranchTaken) begin
         win_code   = SEL_BR;
         win_target = BranchAddress;
      end else begin
         req_valid  = 1'b0;
         win_code   = SEL_SEQ;
         win_target = PC + 32'd4;
      end
   end

   // raw_target keeps the unaligned target so a misaligned redirect can be flagged when applied
   always_comb begin
      state_nxt  = state;
      SelCode    = SEL_SEQ;
      raw_target = PC + 32'd4;
      apply      = 1'b0;
      latch      = 1'b0;
      case (state)
         RUN: begin
            if (req_valid) begin
               SelCode    = win_code;
               raw_target = win_target;
               if (Stall) begin
                  latch     = 1'b1;
                  state_nxt = PEND;
               end else begin
                  apply = 1'b1;
               end
            end
         end
         PEND: begin
            SelCode    = pend_code;
            raw_target = pend_target;
            if (!Stall) begin
               apply     = 1'b1;
               state_nxt = RUN;
            end
         end
         default: state_nxt = RUN;
      endcase
      NextAddress = {raw_target[31:2], 2'b00};
      IF_Flush    = apply;
      if (!Rst_n) begin
         SelCode     = SEL_SEQ;
         NextAddress = RESET_VECTOR + 32'd4;
         IF_Flush    = 1'b0;
         apply       = 1'b0;
         latch       = 1'b0;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         state         <= RUN;
         PC            <= RESET_VECTOR;
         pend_code     <= SEL_SEQ;
         pend_target   <= 32'd0;
         AddrErr       <= 1'b0;
         RedirectCount <= '0;
      end else begin
         state <= state_nxt;
         if (latch) begin
            pend_code   <= win_code;
            pend_target <= win_target;
         end
         if (!Stall) begin
            PC <= NextAddress;
         end
         if (apply) begin
            if (raw_target[1:0] != 2'b00) begin
               AddrErr <= 1'b1;
            end
            if (RedirectCount != {CNT_W{1'b1}}) begin
               RedirectCount <= RedirectCount + CNT_W'(1);
            end
         end
      end
   end

endmodule

// File: tb/tb_pc_redirect_ctrl.sv
// tb/tb_pc_redirect_ctrl.sv - directed and random checks of pc_redirect_ctrl against a behavioural model
module tb_pc_redirect_ctrl;

   localparam logic [31:0] RV    = 32'h0000_0000;
   localparam int          CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst_n, stall, jr_req, j_req, br_req, br_taken;
   logic [31:0]      jr_addr, j_addr, br_addr;
   logic [31:0]      pc;
   logic [1:0]       sel_code;
   logic [31:0]      next_addr;
   logic             if_flush, addr_err;
   logic [CNT_W-1:0] redirect_cnt;

   int checks = 0;
   int errors = 0;

   // reference state: a single optional pending redirect plus architectural registers
   logic [31:0] m_pc;
   bit          m_pending;
   logic [1:0]  m_pcode;
   logic [31:0] m_ptarget;
   bit          m_err;
   int          m_cnt;

   always #5 clk = ~clk;

   pc_redirect_ctrl #(.RESET_VECTOR(RV), .CNT_W(CNT_W)) dut (
      .Clk(clk), .Rst_n(rst_n), .Stall(stall),
      .JRReq(jr_req), .JReq(j_req), .BranchReq(br_req), .BranchTaken(br_taken),
      .JRAddress(jr_addr), .JumpAddress(j_addr), .BranchAddress(br_addr),
      .PC(pc), .SelCode(sel_code), .NextAddress(next_addr),
      .IF_Flush(if_flush), .AddrErr(addr_err), .RedirectCount(redirect_cnt)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic apply_redirect(input logic [31:0] tgt);
      m_pc = {tgt[31:2], 2'b00};
      if (tgt[1:0] != 2'b00) m_err = 1;
      if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
   endtask

   task automatic model_reset();
      m_pc = RV; m_pending = 0; m_pcode = 2'b11; m_ptarget = 0; m_err = 0; m_cnt = 0;
   endtask

   // One clock: drive inputs after the falling edge, check mid-cycle, advance the model at the rising edge.
   task automatic cycle(input bit r, input bit s, input bit jr, input bit j, input bit br, input bit bt,
                        input logic [31:0] jra, input logic [31:0] ja, input logic [31:0] ba);
      bit          valid;
      logic [1:0]  wcode;
      logic [31:0] wtgt;
      logic [1:0]  e_sel;
      logic [31:0] e_na;
      bit          e_fl;
      rst_n = r; stall = s; jr_req = jr; j_req = j; br_req = br; br_taken = bt;
      jr_addr = jra; j_addr = ja; br_addr = ba;
      valid = 1; wcode = 2'b00; wtgt = jra;
      if (jr)            begin wcode = 2'b00; wtgt = jra; end
      else if (j)        begin wcode = 2'b01; wtgt = ja;  end
      else if (br && bt) begin wcode = 2'b10; wtgt = ba;  end
      else valid = 0;
      if (!r)             begin e_sel = 2'b11;   e_na = RV + 32'd4;               e_fl = 0;  end
      else if (m_pending) begin e_sel = m_pcode; e_na = m_ptarget & ~32'd3;        e_fl = !s; end
      else if (valid)     begin e_sel = wcode;   e_na = wtgt & ~32'd3;             e_fl = !s; end
      else                begin e_sel = 2'b11;   e_na = m_pc + 32'd4;              e_fl = 0;  end
      #1;
      check("pc",       pc,                  m_pc);
      check("sel",      32'(sel_code),       32'(e_sel));
      check("next",     next_addr,           e_na);
      check("flush",    32'(if_flush),       32'(e_fl));
      check("addr_err", 32'(addr_err),       32'(m_err));
      check("count",    32'(redirect_cnt),   32'(m_cnt));
      @(posedge clk);
      if (!r) model_reset();
      else if (m_pending) begin
         if (!s) begin apply_redirect(m_ptarget); m_pending = 0; end
      end else if (valid) begin
         if (s) begin m_pending = 1; m_pcode = wcode; m_ptarget = wtgt; end
         else apply_redirect(wtgt);
      end else if (!s) m_pc = m_pc + 32'd4;
      @(negedge clk);
   endtask

   task automatic idle(input bit s);
      cycle(1, s, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic jump(input logic [31:0] t);
      cycle(1, 0, 0, 1, 0, 0, 32'h0, t, 32'h0);
   endtask

   initial begin
      model_reset();
      rst_n = 0; stall = 0; jr_req = 0; j_req = 0; br_req = 0; br_taken = 0;
      jr_addr = 0; j_addr = 0; br_addr = 0;
      @(negedge clk);

      // reset then free-run
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0, 0);
      check("fr_pc0", pc, 32'h0);
      idle(0); check("fr_pc4", pc, 32'h4);
      idle(0); check("fr_pc8", pc, 32'h8);
      idle(0); check("fr_pc12", pc, 32'hC);
      idle(0); check("fr_pc16", pc, 32'h10);

      // simultaneous requests: JR wins
      cycle(1, 0, 1, 1, 1, 1, 32'h100, 32'h200, 32'h300);
      check("sim_pc", pc, 32'h100);
      check("sim_cnt", 32'(redirect_cnt), 32'd1);

      // branch not taken
      jump(32'h20);
      cycle(1, 0, 0, 0, 1, 0, 32'h0, 32'h0, 32'h900);
      check("bnt_pc", pc, 32'h24);

      // stalled redirect; the later branch is ignored
      cycle(1, 1, 0, 1, 0, 0, 32'h0, 32'h400, 32'h0);
      cycle(1, 1, 0, 0, 1, 1, 32'h0, 32'h0, 32'h500);
      idle(1);
      check("stall_pc", pc, 32'h24);
      idle(0);
      check("stall_tgt", pc, 32'h400);
      check("stall_cnt", 32'(redirect_cnt), 32'd3);

      // reset while pending
      cycle(1, 1, 1, 0, 0, 0, 32'h80, 32'h0, 32'h0);
      cycle(0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0);
      check("rp_pc", pc, RV);
      idle(0); idle(0);
      check("rp_after", pc, 32'h8);
      check("rp_cnt", 32'(redirect_cnt), 32'd0);

      // misaligned target
      cycle(1, 0, 1, 0, 0, 0, 32'h102, 32'h0, 32'h0);
      check("mis_pc", pc, 32'h100);
      check("mis_err", 32'(addr_err), 32'd1);
      idle(0); idle(0);
      check("mis_sticky", 32'(addr_err), 32'd1);

      // saturation: 15 redirects reach all-ones, one more holds
      for (int i = 0; i < 15; i++) jump(32'h200);
      check("sat_15", 32'(redirect_cnt), 32'd15);
      jump(32'h240);
      check("sat_hold", 32'(redirect_cnt), 32'd15);

      // sequential wrap
      jump(32'hFFFF_FFFC);
      idle(0);
      check("wrap", pc, 32'h0);

      // random traffic
      for (int i = 0; i < 3000; i++) begin
         bit r;
         logic [31:0] a0, a1, a2;
         r  = ($urandom_range(0, 79) != 0);
         a0 = $urandom; a1 = $urandom; a2 = $urandom;
         if ($urandom_range(0, 3) != 0) begin a0[1:0] = 0; a1[1:0] = 0; a2[1:0] = 0; end
         cycle(r, $urandom_range(0, 2) == 0,
               $urandom_range(0, 7) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
               a0, a1, a2);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/pc_redirect_ctrl.md
# pc_redirect_ctrl

Fetch-stage program-counter controller and the producing end of the next-address select path. It owns the PC register and arbitrates jump-register, jump and taken-branch redirect requests from the execute stage. It drives the 2-bit next-address select code and target into the fetch next-address mux and flushes the IF/ID register on every applied redirect. It also buffers a redirect that arrives while the pipeline is stalled, and keeps a saturating redirect counter for performance debug.

## Interface
Parameters:
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- CNT_W, 16, width of the redirect counter.

Ports:
- Clk  input  1  clock; all state updates on rising edge.
- Rst_n  input  1  reset, synchronous, active-low.
- Stall  input  1  hazard/memory stall; PC and pending state hold while high.
- JRReq  input  1  jump-register redirect request (single-cycle pulse).
- JReq  input  1  jump redirect request (pulse).
- BranchReq  input  1  conditional branch resolved this cycle (pulse).
- BranchTaken  input  1  branch outcome; qualifies BranchReq.
- JRAddress  input  32  JR target.
- JumpAddress  input  32  J target.
- BranchAddress  input  32  branch target.
- PC  output  32  current fetch address (registered).
- SelCode  output  2  next-address select: 00 JR, 01 J, 10 branch, 11 sequential (PC+4).
- NextAddress  output  32  address loaded into PC at the next non-stalled edge (combinational).
- IF_Flush  output  1  kill the instruction in IF/ID this cycle (combinational).
- AddrErr  output  1  sticky; set when an applied target has bits [1:0] != 00.
- RedirectCount  output  CNT_W  number of applied redirects, saturating.

## Operation
- Request qualification: valid = JRReq | JReq | (BranchReq & BranchTaken). BranchReq with BranchTaken=0 is not a redirect.
- Priority when several requests are valid in the same cycle: JR > J > branch. Lower-priority requests are discarded.
- Two-state FSM:
  - RUN:
    - Stall=0 and valid request: SelCode and NextAddress take the winner, IF_Flush=1, PC <= target, RedirectCount increments. State stays RUN.
    - Stall=1 and valid request: latch the winner's code and target into the pending registers and go to PEND. PC holds and IF_Flush=0.
    - No request: SelCode=11, NextAddress=PC+4 (mod 2^32), and PC advances when Stall=0.
  - PEND:
    - SelCode and NextAddress come from the pending registers. New requests are ignored, because the pending redirect belongs to an older instruction.
    - Stall=1: hold.
    - Stall=0: IF_Flush=1, PC <= pending target, RedirectCount increments, go to RUN.
- Target bits [1:0] are forced to 00 when loaded into PC. If the raw target had nonzero low bits, AddrErr is set and stays set until reset.
- RedirectCount saturates at all-ones.
- Reset (Rst_n=0 at an edge, in any state, including mid-PEND): PC=RESET_VECTOR, state RUN, pending registers cleared, AddrErr=0, RedirectCount=0. Any pending redirect is dropped.
- While Rst_n=0, the combinational outputs are forced to SelCode=11, NextAddress=RESET_VECTOR+4 and IF_Flush=0.

## Timing
- Redirect latency, unstalled: request in cycle n; IF_Flush=1 in cycle n; PC=target from cycle n+1.
- Redirect latency, stalled: request in cycle n with Stall=1; IF_Flush stays low while stalled. In the first cycle m>n with Stall=0, IF_Flush=1 and SelCode is the pending code. PC=target in cycle m+1.
- IF_Flush is never high while Stall=1, and it is high for exactly one cycle per applied redirect.
- Sequential wrap: PC=32'hFFFF_FFFC with no redirect gives PC=32'h0000_0000 next cycle.
- Every output has a defined value in the first cycle after reset release.

## Test plan
- Reset then free-run: Rst_n low 2 cycles, release with Stall=0 and no requests. Required: PC=0, 4, 8, 12 on consecutive cycles, SelCode=11, IF_Flush=0, RedirectCount=0.
- Simultaneous requests: at PC=0x10, raise JRReq, JReq and BranchReq with BranchTaken=1 together, targets JR=0x100, J=0x200, BR=0x300. Required: SelCode=00, IF_Flush=1 for one cycle, PC=0x100 next cycle, RedirectCount=1.
- Branch not taken: BranchReq=1, BranchTaken=0 at PC=0x20. Required: SelCode=11, no flush, PC=0x24.
- Stalled redirect: Stall=1 for 3 cycles, JReq pulse to 0x400 in the first of them, then a BranchReq/Taken pulse to 0x500 in the second. Required: PC frozen and IF_Flush=0 during the stall; in the first unstalled cycle SelCode=01 and IF_Flush=1; PC=0x400 next cycle; the branch is ignored; count +1.
- Reset mid-PEND: enter PEND with a JR to 0x80, then assert Rst_n=0 while Stall=1. Required: PC=RESET_VECTOR, PEND cleared, no later flush to 0x80.
- Misaligned target and saturation: JR target 0x102. Required: PC=0x100 and AddrErr=1 stays set. Separately, force the count to all-ones with CNT_W=4 (15 redirects) and apply one more redirect: RedirectCount stays at 15.
